// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, size codes, FSM states for the memory port arbiter
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_1  = 2'b00;
  localparam logic [1:0] SZ_4  = 2'b01;
  localparam logic [1:0] SZ_8  = 2'b10;
  localparam logic [1:0] SZ_16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

  function automatic logic [4:0] size_beats(input logic [1:0] size);
    case (size)
      SZ_1:    size_beats = 5'd1;
      SZ_4:    size_beats = 5'd4;
      SZ_8:    size_beats = 5'd8;
      default: size_beats = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// rtl/mem_rr_picker.sv - two-input one-hot winner select, round-robin or fixed priority
// MEM_ARB_FIXED_PRIO_EN: port 1 always wins ties and rr_last is ignored.
module mem_rr_picker (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (&req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win = 2'b10;
`else
      win = rr_last ? 2'b01 : 2'b10;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter and burst sequencer for the unified memory
// Tie-break policy selected in mem_rr_picker (MEM_ARB_FIXED_PRIO_EN).
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          p0_req,
  input  logic          p0_rw,
  input  logic [AW-1:0] p0_addr,
  input  logic [1:0]    p0_size,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_wready,
  output logic          p0_rvalid,
  output logic          p0_done,
  input  logic          p1_req,
  input  logic          p1_rw,
  input  logic [AW-1:0] p1_addr,
  input  logic [1:0]    p1_size,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_wready,
  output logic          p1_rvalid,
  output logic          p1_done,
  output logic [DW-1:0] rd_data,
  output logic          mem_enable,
  output logic          mem_rw,
  output logic [AW-1:0] mem_address,
  output logic [1:0]    mem_access_size,
  output logic [DW-1:0] mem_data_in,
  input  logic          mem_busy,
  input  logic [DW-1:0] mem_data_out
);

  arb_state_t    state, next_state;
  logic          own_q;
  logic          rw_q;
  logic [AW-1:0] base_q;
  logic [1:0]    size_q;
  logic [3:0]    beat_q;
  logic [3:0]    last_q;
  logic          rr_last;
  logic          rvalid_q;
  logic          rvalid_own_q;
  logic [1:0]    win;
  logic [4:0]    beats_m1;
  logic          in_burst;
  logic          accept;

  mem_rr_picker u_picker (
    .req     ({p1_req, p0_req}),
    .rr_last (rr_last),
    .win     (win)
  );

  assign in_burst = (state == ST_BURST);
  assign accept   = in_burst && !mem_busy;
  assign beats_m1 = size_beats(win[1] ? p1_size : p0_size) - 5'd1;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (p0_req || p1_req) next_state = ST_BURST;
      ST_BURST: if (accept && beat_q == last_q) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      own_q        <= 1'b0;
      rw_q         <= 1'b0;
      base_q       <= '0;
      size_q       <= 2'b00;
      beat_q       <= 4'd0;
      last_q       <= 4'd0;
      rr_last      <= 1'b1;
      rvalid_q     <= 1'b0;
      rvalid_own_q <= 1'b0;
    end else begin
      state        <= next_state;
      rvalid_q     <= accept && !rw_q;
      rvalid_own_q <= own_q;
      if (state == ST_IDLE && (p0_req || p1_req)) begin
        own_q  <= win[1];
        rw_q   <= win[1] ? p1_rw   : p0_rw;
        base_q <= win[1] ? p1_addr : p0_addr;
        size_q <= win[1] ? p1_size : p0_size;
        beat_q <= 4'd0;
        last_q <= beats_m1[3:0];
      end
      if (accept) beat_q <= beat_q + 4'd1;
      if (state == ST_DONE) rr_last <= own_q;
    end
  end

  // Ownership lasts through DONE; gnt falls on the return to IDLE.
  assign p0_gnt    = (state != ST_IDLE) && !own_q;
  assign p1_gnt    = (state != ST_IDLE) &&  own_q;
  assign p0_wready = accept && rw_q && !own_q;
  assign p1_wready = accept && rw_q &&  own_q;
  assign p0_rvalid = rvalid_q && !rvalid_own_q;
  assign p1_rvalid = rvalid_q &&  rvalid_own_q;
  assign p0_done   = (state == ST_DONE) && !own_q;
  assign p1_done   = (state == ST_DONE) &&  own_q;
  assign rd_data   = rvalid_q ? mem_data_out : '0;

  assign mem_enable      = in_burst;
  assign mem_rw          = in_burst && rw_q;
  assign mem_address     = in_burst ? base_q + {{(AW-6){1'b0}}, beat_q, 2'b00} : '0;
  assign mem_access_size = in_burst ? size_q : 2'b00;
  assign mem_data_in     = in_burst ? (own_q ? p1_wdata : p0_wdata) : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req = 1'b0, p0_rw = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic [1:0]  p0_size = 2'b00;
  logic        p0_gnt, p0_wready, p0_rvalid, p0_done;
  logic        p1_req = 1'b0, p1_rw = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic [1:0]  p1_size = 2'b00;
  logic        p1_gnt, p1_wready, p1_rvalid, p1_done;
  logic [31:0] rd_data;
  logic        mem_enable, mem_rw;
  logic [31:0] mem_address, mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_data_out = '0;

  int total = 0;
  int bad = 0;

  mem_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_size(p0_size), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_wready(p0_wready), .p0_rvalid(p0_rvalid), .p0_done(p0_done),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_size(p1_size), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_wready(p1_wready), .p1_rvalid(p1_rvalid), .p1_done(p1_done),
    .rd_data(rd_data), .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_address(mem_address),
    .mem_access_size(mem_access_size), .mem_data_in(mem_data_in),
    .mem_busy(mem_busy), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  // Memory returns the inverted beat address one cycle after a read beat is accepted.
  always @(posedge clock)
    if (mem_enable && !mem_busy && !mem_rw) mem_data_out <= ~mem_address;

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock); #1;
    total++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got %b%b want 00", p1_gnt, p0_gnt); end
    total++; if (mem_enable !== 1'b0 || mem_address !== 32'h0) begin bad++; $display("FAIL reset_mem got en=%b addr=%h want 0", mem_enable, mem_address); end
    total++; if (p0_done !== 1'b0 || p1_done !== 1'b0 || rd_data !== 32'h0) begin bad++; $display("FAIL reset_resp got done=%b%b rd=%h want 0", p1_done, p0_done, rd_data); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clock);
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 32'h100; p0_size = 2'b00;
    @(negedge clock); #1;
    total++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin bad++; $display("FAIL sr_gnt got %b%b want 01", p1_gnt, p0_gnt); end
    total++; if (mem_enable !== 1'b1 || mem_rw !== 1'b0) begin bad++; $display("FAIL sr_en got en=%b rw=%b want 1 0", mem_enable, mem_rw); end
    total++; if (mem_address !== 32'h100) begin bad++; $display("FAIL sr_addr got %h want 00000100", mem_address); end
    @(negedge clock); #1;
    total++; if (p0_rvalid !== 1'b1 || rd_data !== 32'hFFFF_FEFF) begin bad++; $display("FAIL sr_rdata got v=%b d=%h want 1 fffffeff", p0_rvalid, rd_data); end
    total++; if (p0_done !== 1'b1 || mem_enable !== 1'b0) begin bad++; $display("FAIL sr_done got done=%b en=%b want 1 0", p0_done, mem_enable); end
    @(negedge clock);
    p0_req = 1'b0; #1;
    total++; if (p0_gnt !== 1'b0 || p0_rvalid !== 1'b0 || p0_done !== 1'b0) begin bad++; $display("FAIL sr_idle got gnt=%b v=%b done=%b want 0", p0_gnt, p0_rvalid, p0_done); end
  endtask

  task automatic test_stalled_write();
    logic [31:0] exp_addr [1:6];
    int k = 0, wr_cnt = 0, done_cnt = 0;
    logic wr_prev = 1'b0;
    exp_addr[1] = 32'h200; exp_addr[2] = 32'h204; exp_addr[3] = 32'h204;
    exp_addr[4] = 32'h204; exp_addr[5] = 32'h208; exp_addr[6] = 32'h20C;
    @(negedge clock);
    p1_req = 1'b1; p1_rw = 1'b1; p1_addr = 32'h200; p1_size = 2'b01; p1_wdata = 32'hD000_0000;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock);
      if (wr_prev) begin k++; p1_wdata = 32'hD000_0000 + k; end
      mem_busy = (cyc == 2 || cyc == 3);
      if (cyc == 8) p1_req = 1'b0;
      #1;
      if (cyc <= 6) begin
        total++; if (mem_enable !== 1'b1 || mem_address !== exp_addr[cyc]) begin bad++; $display("FAIL sw_addr c%0d got en=%b %h want 1 %h", cyc, mem_enable, mem_address, exp_addr[cyc]); end
      end
      if (p1_wready) begin
        wr_cnt++;
        total++; if (mem_data_in !== 32'hD000_0000 + k) begin bad++; $display("FAIL sw_data c%0d got %h want %h", cyc, mem_data_in, 32'hD000_0000 + k); end
      end
      if (p1_done) begin
        done_cnt++;
        total++; if (cyc != 7) begin bad++; $display("FAIL sw_done_cycle got %0d want 7", cyc); end
      end
      wr_prev = p1_wready;
    end
    mem_busy = 1'b0;
    total++; if (wr_cnt != 4) begin bad++; $display("FAIL sw_wready_count got %0d want 4", wr_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL sw_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_round_robin();
    logic [9:1] e0, e1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    e0 = 9'b0_0_0_0_0_0_0_0_0;
    e1 = 9'b0_1_1_0_1_1_0_1_1;
`else
    e0 = 9'b0_1_1_0_0_0_0_1_1;
    e1 = 9'b0_0_0_0_1_1_0_0_0;
`endif
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 32'h10; p0_size = 2'b00;
    p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 32'h20; p1_size = 2'b00;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      if (c == 9) begin p0_req = 1'b0; p1_req = 1'b0; end
      #1;
      total++; if (p0_gnt !== e0[c] || p1_gnt !== e1[c]) begin bad++; $display("FAIL rr_gnt c%0d got %b%b want %b%b", c, p1_gnt, p0_gnt, e1[c], e0[c]); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] base = 32'hFFFF_FFF8;
    logic [31:0] ea;
    int rv_cnt = 0, done_cnt = 0;
    @(negedge clock);
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = base; p0_size = 2'b11;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      if (c == 18) p0_req = 1'b0;
      #1;
      if (c <= 16) begin
        ea = base + 32'(4 * (c - 1));
        total++; if (mem_address !== ea || mem_access_size !== 2'b11) begin bad++; $display("FAIL wr_addr c%0d got %h sz=%b want %h 11", c, mem_address, mem_access_size, ea); end
      end
      if (c == 3) begin
        total++; if (mem_address !== 32'h0) begin bad++; $display("FAIL wr_zero got %h want 00000000", mem_address); end
      end
      if (c == 16) begin
        total++; if (mem_address !== 32'h34) begin bad++; $display("FAIL wr_last got %h want 00000034", mem_address); end
      end
      if (p0_rvalid) begin
        ea = ~(base + 32'(4 * rv_cnt));
        rv_cnt++;
        total++; if (rd_data !== ea) begin bad++; $display("FAIL wr_rdata beat%0d got %h want %h", rv_cnt, rd_data, ea); end
      end
      if (p0_done) begin
        done_cnt++;
        total++; if (c != 17 || p0_rvalid !== 1'b1) begin bad++; $display("FAIL wr_done got c%0d v=%b want c17 v=1", c, p0_rvalid); end
      end
    end
    total++; if (rv_cnt != 16) begin bad++; $display("FAIL wr_rvalid_count got %0d want 16", rv_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wr_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    int done_seen = 0;
    @(negedge clock);
    p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 32'h400; p1_size = 2'b10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock); #1;
      if (p1_done) done_seen++;
    end
    total++; if (mem_address !== 32'h40C) begin bad++; $display("FAIL rm_beat3 got %h want 0000040c", mem_address); end
    reset_n = 1'b0; #1;
    total++; if (p1_gnt !== 1'b0 || mem_enable !== 1'b0 || mem_address !== 32'h0) begin bad++; $display("FAIL rm_async got gnt=%b en=%b addr=%h want 0", p1_gnt, mem_enable, mem_address); end
    total++; if (p1_rvalid !== 1'b0 || rd_data !== 32'h0 || p1_done !== 1'b0) begin bad++; $display("FAIL rm_resp got v=%b rd=%h done=%b want 0", p1_rvalid, rd_data, p1_done); end
    p1_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      if (p1_done || p0_done) done_seen++;
    end
    reset_n = 1'b1;
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 32'h80; p0_size = 2'b00;
    @(negedge clock); #1;
    total++; if (p0_gnt !== 1'b1 || mem_address !== 32'h80) begin bad++; $display("FAIL rm_regrant got gnt=%b addr=%h want 1 00000080", p0_gnt, mem_address); end
    @(negedge clock); #1;
    total++; if (p0_done !== 1'b1 || rd_data !== 32'hFFFF_FF7F) begin bad++; $display("FAIL rm_newdone got done=%b rd=%h want 1 ffffff7f", p0_done, rd_data); end
    @(negedge clock);
    p0_req = 1'b0;
    total++; if (done_seen != 0) begin bad++; $display("FAIL rm_no_done got %0d want 0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_stalled_write();
    test_round_robin();
    test_wrap();
    test_reset_mid_burst();
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
